// File: rtl/map_table_pkg.sv
// map_table_pkg: shared rename-stage types and widths.
//   PR / AR      : physical / architectural register index widths
//   WAYS         : superscalar width (slot WAYS-1 is oldest, slot 0 youngest)
//   rename_req_t : per-slot view of a dispatching instruction
package map_table_pkg;

  localparam int unsigned PR        = 6;
  localparam int unsigned AR        = 5;
  localparam int unsigned WAYS      = 3;
  localparam int unsigned NUM_AREGS = 1 << AR;
  localparam int unsigned NUM_PREGS = 1 << PR;

  typedef logic [PR-1:0] preg_t;
  typedef logic [AR-1:0] areg_t;

  typedef struct packed {
    logic  valid;
    logic  dest_valid;
    areg_t dest;
    areg_t src1;
    areg_t src2;
  } rename_req_t;

  // A slot takes a new physical tag only if it writes a real (non-zero) areg.
  function automatic logic allocates(rename_req_t req);
    return req.valid & req.dest_valid & (req.dest != '0);
  endfunction

endpackage

// File: rtl/map_table_if.sv
// map_table_if: dispatch / free-list / CDB / ROB-retire signals of the map table.
//   master : the surrounding pipeline (drives requests, reads renamed tags)
//   slave  : the map table itself
interface map_table_if;

  logic [map_table_pkg::WAYS-1:0]                       DispatchEN;
  logic [map_table_pkg::WAYS-1:0]                       dest_valid;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::AR-1:0] dest_areg;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::AR-1:0] src1_areg;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::AR-1:0] src2_areg;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::PR-1:0] FreeReg;
  logic [map_table_pkg::WAYS-1:0]                       FLDispatchEN;
  logic [map_table_pkg::WAYS-1:0]                       CDB_valid;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::PR-1:0] CDB_tag;
  logic [map_table_pkg::WAYS-1:0]                       RetireEN;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::AR-1:0] retire_areg;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::PR-1:0] retire_preg;
  logic                                                 BPRecoverEN;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::PR-1:0] src1_preg;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::PR-1:0] src2_preg;
  logic [map_table_pkg::WAYS-1:0]                       src1_ready;
  logic [map_table_pkg::WAYS-1:0]                       src2_ready;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::PR-1:0] dest_preg;
  logic [map_table_pkg::WAYS-1:0][map_table_pkg::PR-1:0] dest_told;

  modport master (
    output DispatchEN, dest_valid, dest_areg, src1_areg, src2_areg, FreeReg,
    output CDB_valid, CDB_tag, RetireEN, retire_areg, retire_preg, BPRecoverEN,
    input  FLDispatchEN, src1_preg, src2_preg, src1_ready, src2_ready,
    input  dest_preg, dest_told
  );

  modport slave (
    input  DispatchEN, dest_valid, dest_areg, src1_areg, src2_areg, FreeReg,
    input  CDB_valid, CDB_tag, RetireEN, retire_areg, retire_preg, BPRecoverEN,
    output FLDispatchEN, src1_preg, src2_preg, src1_ready, src2_ready,
    output dest_preg, dest_told
  );

endinterface

// File: rtl/map_bypass.sv
// map_bypass: intra-bundle rename bypass for one lookup field.
//   i_alloc       : slot allocates a new tag this cycle
//   i_dest_areg   : destination areg of each slot
//   i_free_reg    : tag being allocated by each slot
//   i_lookup_areg : areg each slot wants translated
//   o_hit         : an older allocating slot writes the looked-up areg
//   o_tag         : that older slot's new tag (nearest older slot wins)
module map_bypass
  import map_table_pkg::*;
(
  input  logic  [WAYS-1:0] i_alloc,
  input  areg_t [WAYS-1:0] i_dest_areg,
  input  preg_t [WAYS-1:0] i_free_reg,
  input  areg_t [WAYS-1:0] i_lookup_areg,
  output logic  [WAYS-1:0] o_hit,
  output preg_t [WAYS-1:0] o_tag
);

  always_comb begin
    o_hit = '0;
    o_tag = '0;
    for (int s = 0; s < WAYS; s++) begin
      // Walk from the oldest slot toward slot s so the nearest older match lands last.
      for (int o = WAYS - 1; o > s; o--) begin
        if (i_alloc[o] && (i_dest_areg[o] == i_lookup_areg[s])) begin
          o_hit[s] = 1'b1;
          o_tag[s] = i_free_reg[o];
        end
      end
    end
  end

endmodule

// File: rtl/map_table.sv
// map_table: 3-wide register-rename map table.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dispatch lookups/allocations, free-list request, CDB wakeup,
//           ROB retire and branch-mispredict recovery (map_table_if.slave)
// Holds a speculative map, an architectural (retired) map and per-preg ready bits.
module map_table
  import map_table_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  map_table_if.slave  bus
);

  preg_t             r_spec_map [NUM_AREGS];
  preg_t             r_arch_map [NUM_AREGS];
  logic [NUM_PREGS-1:0] r_ready;

  preg_t             w_spec_next [NUM_AREGS];
  preg_t             w_arch_next [NUM_AREGS];
  logic [NUM_PREGS-1:0] w_ready_next;

  rename_req_t [WAYS-1:0] w_req;
  logic        [WAYS-1:0] w_alloc;
  logic        [WAYS-1:0] w_s1_hit, w_s2_hit, w_told_hit;
  preg_t       [WAYS-1:0] w_s1_tag, w_s2_tag, w_told_tag;

  always_comb begin
    for (int s = 0; s < WAYS; s++) begin
      w_req[s].valid      = bus.DispatchEN[s];
      w_req[s].dest_valid = bus.dest_valid[s];
      w_req[s].dest       = bus.dest_areg[s];
      w_req[s].src1       = bus.src1_areg[s];
      w_req[s].src2       = bus.src2_areg[s];
      w_alloc[s]          = allocates(w_req[s]);
    end
  end

  assign bus.FLDispatchEN = w_alloc;

  map_bypass u_bypass_src1 (
    .i_alloc       (w_alloc),
    .i_dest_areg   (bus.dest_areg),
    .i_free_reg    (bus.FreeReg),
    .i_lookup_areg (bus.src1_areg),
    .o_hit         (w_s1_hit),
    .o_tag         (w_s1_tag)
  );

  map_bypass u_bypass_src2 (
    .i_alloc       (w_alloc),
    .i_dest_areg   (bus.dest_areg),
    .i_free_reg    (bus.FreeReg),
    .i_lookup_areg (bus.src2_areg),
    .o_hit         (w_s2_hit),
    .o_tag         (w_s2_tag)
  );

  map_bypass u_bypass_told (
    .i_alloc       (w_alloc),
    .i_dest_areg   (bus.dest_areg),
    .i_free_reg    (bus.FreeReg),
    .i_lookup_areg (bus.dest_areg),
    .o_hit         (w_told_hit),
    .o_tag         (w_told_tag)
  );

  // Source lookup: areg 0 is hardwired; bypassed tags are by definition not yet
  // produced; otherwise a same-cycle CDB broadcast forwards readiness.
  always_comb begin
    bus.src1_preg  = '0;
    bus.src2_preg  = '0;
    bus.src1_ready = '1;
    bus.src2_ready = '1;
    bus.dest_preg  = '0;
    bus.dest_told  = '0;
    for (int s = 0; s < WAYS; s++) begin
      if (bus.src1_areg[s] != '0) begin
        if (w_s1_hit[s]) begin
          bus.src1_preg[s]  = w_s1_tag[s];
          bus.src1_ready[s] = 1'b0;
        end else begin
          bus.src1_preg[s]  = r_spec_map[bus.src1_areg[s]];
          bus.src1_ready[s] = r_ready[r_spec_map[bus.src1_areg[s]]];
          for (int c = 0; c < WAYS; c++) begin
            if (bus.CDB_valid[c] && (bus.CDB_tag[c] == r_spec_map[bus.src1_areg[s]])) begin
              bus.src1_ready[s] = 1'b1;
            end
          end
        end
      end
      if (bus.src2_areg[s] != '0) begin
        if (w_s2_hit[s]) begin
          bus.src2_preg[s]  = w_s2_tag[s];
          bus.src2_ready[s] = 1'b0;
        end else begin
          bus.src2_preg[s]  = r_spec_map[bus.src2_areg[s]];
          bus.src2_ready[s] = r_ready[r_spec_map[bus.src2_areg[s]]];
          for (int c = 0; c < WAYS; c++) begin
            if (bus.CDB_valid[c] && (bus.CDB_tag[c] == r_spec_map[bus.src2_areg[s]])) begin
              bus.src2_ready[s] = 1'b1;
            end
          end
        end
      end
      if (w_alloc[s]) begin
        bus.dest_preg[s] = bus.FreeReg[s];
        bus.dest_told[s] = w_told_hit[s] ? w_told_tag[s] : r_spec_map[bus.dest_areg[s]];
      end
    end
  end

  // Retire always commits, even in the recovery cycle, so recovery sees it.
  always_comb begin
    w_arch_next = r_arch_map;
    for (int s = WAYS - 1; s >= 0; s--) begin
      if (bus.RetireEN[s] && (bus.retire_areg[s] != '0)) begin
        w_arch_next[bus.retire_areg[s]] = bus.retire_preg[s];
      end
    end
  end

  always_comb begin
    if (bus.BPRecoverEN) begin
      w_spec_next  = w_arch_next;
      w_ready_next = '1;
    end else begin
      w_spec_next  = r_spec_map;
      w_ready_next = r_ready;
      for (int c = 0; c < WAYS; c++) begin
        if (bus.CDB_valid[c]) w_ready_next[bus.CDB_tag[c]] = 1'b1;
      end
      // Applied after the CDB sets so a re-allocated tag stays not-ready.
      for (int s = WAYS - 1; s >= 0; s--) begin
        if (w_alloc[s]) begin
          w_spec_next[bus.dest_areg[s]] = bus.FreeReg[s];
          w_ready_next[bus.FreeReg[s]]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        r_spec_map[i] <= preg_t'(i);
        r_arch_map[i] <= preg_t'(i);
      end
      r_ready <= '1;
    end else begin
      r_spec_map <= w_spec_next;
      r_arch_map <= w_arch_next;
      r_ready    <= w_ready_next;
    end
  end

endmodule
